srio_link_monitor: RTL and testbench

Synthesizable, parametrised link-bring-up monitor for NUM_PORTS SRIO gen2 example instances sharing one system clock. Per port, it:
- debounces the core status bits (clock lock, port init, link init, 1x mode);
- runs a bring-up state machine with a timeout watchdog;
- counts link drops;
- queues UP/DOWN/TIMEOUT events to a single valid/ready event port.

It replaces simulation-only $display link reporting with hardware status usable on-board and in loopback benches.

---
 rtl/srio_link_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_srio_link_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/srio_link_monitor.sv
// Link bring-up monitor for NUM_PORTS SRIO instances: debounced status, bring-up FSM
// with watchdog, saturating drop counters and a round-robin event port.
//
// state  | meaning
// S_LOCK | waiting for filtered clock lock
// S_PORT | lock held, waiting for port_initialized
// S_LINK | port up, waiting for link_initialized
// S_UP   | link operational (link_up=1)
// S_DOWN | one-cycle drop marker, returns to S_LOCK
// S_FAIL | watchdog expired, waits for all status bits together
module srio_link_monitor #(
    parameter int NUM_PORTS      = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16,
    localparam int PW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_PORTS-1:0]       clk_lock,
    input  logic [NUM_PORTS-1:0]       port_init,
    input  logic [NUM_PORTS-1:0]       link_init,
    input  logic [NUM_PORTS-1:0]       mode_1x,
    input  logic                       clr_stats,
    output logic [NUM_PORTS-1:0]       link_up,
    output logic                       all_up,
    output logic [NUM_PORTS-1:0]       mode_1x_f,
    output logic [NUM_PORTS-1:0]       timeout_err,
    output logic [NUM_PORTS*CNT_W-1:0] drop_cnt,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [PW-1:0]              evt_port,
    output logic [1:0]                 evt_code,
    output logic                       evt_overflow
);
    localparam int NB = 4 * NUM_PORTS;
    localparam int FW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0] EVT_UP   = 2'd1;
    localparam logic [1:0] EVT_DOWN = 2'd2;
    localparam logic [1:0] EVT_TMO  = 2'd3;

    typedef enum logic [2:0] {S_LOCK, S_PORT, S_LINK, S_UP, S_DOWN, S_FAIL} state_t;

    logic [NB-1:0]        raw_all, filt_all;
    logic [FW-1:0]        flt_cnt [NB];
    logic [NUM_PORTS-1:0] f_lock, f_port, f_link;

    state_t               state     [NUM_PORTS];
    state_t               nxt_state [NUM_PORTS];
    logic [TW-1:0]        timer     [NUM_PORTS];
    logic [CNT_W-1:0]     drop_q    [NUM_PORTS];
    logic [1:0]           new_code  [NUM_PORTS];
    logic [1:0]           pend_code [NUM_PORTS];
    logic [NUM_PORTS-1:0] new_evt, drop_hit, tmo_hit, up_nxt, in_bu, pend_vld, taken;
    logic [PW-1:0]        rr_ptr, gnt_idx;
    logic                 gnt_any, load, ovf_set;

    assign raw_all   = {mode_1x, link_init, port_init, clk_lock};
    assign f_lock    = filt_all[0 +: NUM_PORTS];
    assign f_port    = filt_all[NUM_PORTS +: NUM_PORTS];
    assign f_link    = filt_all[2*NUM_PORTS +: NUM_PORTS];
    assign mode_1x_f = filt_all[3*NUM_PORTS +: NUM_PORTS];

    // A filtered bit only follows raw after STABLE_CYCLES consecutive differing samples.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            filt_all <= '0;
            for (int i = 0; i < NB; i++) flt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (raw_all[i] == filt_all[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FW'(STABLE_CYCLES - 1)) begin
                    filt_all[i] <= raw_all[i];
                    flt_cnt[i]  <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            nxt_state[p] = state[p];
            new_evt[p]   = 1'b0;
            new_code[p]  = EVT_UP;
            drop_hit[p]  = 1'b0;
            tmo_hit[p]   = 1'b0;
            in_bu[p]     = (TIMEOUT_CYCLES > 0) && (state[p] inside {S_LOCK, S_PORT, S_LINK});
            case (state[p])
                S_LOCK: if (f_lock[p]) nxt_state[p] = S_PORT;
                S_PORT: begin
                    if (!f_lock[p])     nxt_state[p] = S_LOCK;
                    else if (f_port[p]) nxt_state[p] = S_LINK;
                end
                S_LINK: begin
                    if (!f_lock[p] || !f_port[p]) begin
                        nxt_state[p] = S_LOCK;
                    end else if (f_link[p]) begin
                        nxt_state[p] = S_UP;
                        new_evt[p]   = 1'b1;
                    end
                end
                S_UP: begin
                    if (!(f_lock[p] && f_port[p] && f_link[p])) begin
                        nxt_state[p] = S_DOWN;
                        new_evt[p]   = 1'b1;
                        new_code[p]  = EVT_DOWN;
                        drop_hit[p]  = 1'b1;
                    end
                end
                S_DOWN: nxt_state[p] = S_LOCK;
                S_FAIL: begin
                    if (f_lock[p] && f_port[p] && f_link[p]) begin
                        nxt_state[p] = S_UP;
                        new_evt[p]   = 1'b1;
                    end
                end
                default: nxt_state[p] = S_LOCK;
            endcase
            // Watchdog expiry overrides any forward step taken in the same cycle.
            if (in_bu[p] && timer[p] == TW'(TIMEOUT_CYCLES - 1)) begin
                nxt_state[p] = S_FAIL;
                new_evt[p]   = 1'b1;
                new_code[p]  = EVT_TMO;
                tmo_hit[p]   = 1'b1;
            end
            up_nxt[p] = (nxt_state[p] == S_UP);
        end
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            int cand;
            cand = (int'(rr_ptr) + k) % NUM_PORTS;
            if (!gnt_any && pend_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(cand);
            end
        end
        load  = !evt_valid && gnt_any;
        taken = '0;
        for (int p = 0; p < NUM_PORTS; p++) taken[p] = load && (gnt_idx == PW'(p));
        ovf_set = |(new_evt & pend_vld & ~taken);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state[p]     <= S_LOCK;
                timer[p]     <= '0;
                drop_q[p]    <= '0;
                pend_code[p] <= '0;
            end
            link_up      <= '0;
            all_up       <= 1'b0;
            timeout_err  <= '0;
            pend_vld     <= '0;
            rr_ptr       <= '0;
            evt_valid    <= 1'b0;
            evt_port     <= '0;
            evt_code     <= '0;
            evt_overflow <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state[p] <= nxt_state[p];
                if (nxt_state[p] != state[p] || !in_bu[p]) timer[p] <= '0;
                else                                       timer[p] <= timer[p] + 1'b1;
                if (clr_stats)                          drop_q[p] <= '0;
                else if (drop_hit[p] && drop_q[p] != '1) drop_q[p] <= drop_q[p] + 1'b1;
                if (clr_stats)       timeout_err[p] <= 1'b0;
                else if (tmo_hit[p]) timeout_err[p] <= 1'b1;
                if (new_evt[p]) begin
                    pend_vld[p]  <= 1'b1;
                    pend_code[p] <= new_code[p];
                end else if (taken[p]) begin
                    pend_vld[p]  <= 1'b0;
                end
            end
            link_up <= up_nxt;
            all_up  <= &up_nxt;
            // The output register only reloads when empty: at most one event per two cycles.
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end else if (load) begin
                evt_valid <= 1'b1;
                evt_port  <= gnt_idx;
                evt_code  <= pend_code[gnt_idx];
                rr_ptr    <= PW'((int'(gnt_idx) + 1) % NUM_PORTS);
            end
            if (clr_stats)    evt_overflow <= 1'b0;
            else if (ovf_set) evt_overflow <= 1'b1;
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) drop_cnt[p*CNT_W +: CNT_W] = drop_q[p];
    end

endmodule

// File: tb/tb_srio_link_monitor.sv
// Bench for srio_link_monitor: bring-up, glitch table, watchdog, arbitration/overflow,
// drop saturation with clear, and mid-operation reset.
module tb_srio_link_monitor;
    localparam int NP = 2;
    localparam int SC = 4;
    localparam int TO = 100;
    localparam int CW = 2;
    localparam logic [1:0] UP = 2'd1, DN = 2'd2, TM = 2'd3;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [NP-1:0]    clk_lock = '0, port_init = '0, link_init = '0, mode_1x = '0;
    logic             clr_stats = 1'b0;
    logic             evt_ready = 1'b1;
    logic [NP-1:0]    link_up, mode_1x_f, timeout_err;
    logic             all_up, evt_valid, evt_overflow;
    logic [NP*CW-1:0] drop_cnt;
    logic [0:0]       evt_port;
    logic [1:0]       evt_code;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [0:0] port; logic [1:0] code; } evt_t;
    evt_t exp_q[$];
    evt_t mon_e;

    typedef struct { int len; int exp_drop; logic drop; } glitch_t;
    glitch_t gt[8];

    srio_link_monitor #(
        .NUM_PORTS(NP), .STABLE_CYCLES(SC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .clk_lock(clk_lock), .port_init(port_init), .link_init(link_init), .mode_1x(mode_1x),
        .clr_stats(clr_stats),
        .link_up(link_up), .all_up(all_up), .mode_1x_f(mode_1x_f), .timeout_err(timeout_err),
        .drop_cnt(drop_cnt),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_port(evt_port), .evt_code(evt_code),
        .evt_overflow(evt_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input logic [0:0] p, input logic [1:0] c);
        exp_q.push_back('{p, c});
    endtask

    // Scoreboard: every accepted event is popped against the queue built by the stimulus.
    always @(negedge sys_clk) begin
        if (!sys_rst && evt_valid && evt_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL evt_unexpected: got port %0d code %0d, expected none", evt_port, evt_code);
            end else begin
                mon_e = exp_q.pop_front();
                if (evt_port !== mon_e.port || evt_code !== mon_e.code) begin
                    n_err++;
                    $display("FAIL evt_order: got port %0d code %0d, expected port %0d code %0d",
                             evt_port, evt_code, mon_e.port, mon_e.code);
                end
            end
        end
    end

    initial begin
        gt[0] = '{3, 0, 1'b0};
        gt[1] = '{4, 1, 1'b1};
        gt[2] = '{1, 1, 1'b0};
        gt[3] = '{6, 2, 1'b1};
        gt[4] = '{2, 2, 1'b0};
        gt[5] = '{5, 3, 1'b1};
        gt[6] = '{4, 3, 1'b1};
        gt[7] = '{7, 3, 1'b1};

        tick(3);
        check("rst_link_up", 32'(link_up), 0);
        check("rst_all_up", 32'(all_up), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);

        // bring-up of port0, 10 cycles between status bits
        sys_rst = 1'b0;
        clk_lock[0] = 1'b1;
        tick(10);
        port_init[0] = 1'b1;
        tick(10);
        link_init[0] = 1'b1;
        mode_1x[0] = 1'b1;
        expect_evt(1'b0, UP);
        tick(4);
        check("bringup_up_early", 32'(link_up[0]), 0);
        check("mode_1x_f_latency", 32'(mode_1x_f), 32'h1);
        tick(1);
        check("bringup_up_at5", 32'(link_up[0]), 1);
        check("bringup_all_up", 32'(all_up), 0);

        // watchdog on port1 (never locked): expiry at cycle 100 after release
        tick(74);
        check("wdog_before", 32'(timeout_err), 0);
        expect_evt(1'b1, TM);
        tick(1);
        check("wdog_at100", 32'(timeout_err), 32'h2);
        check("wdog_no_link", 32'(link_up[1]), 0);
        clk_lock[1] = 1'b1; port_init[1] = 1'b1; link_init[1] = 1'b1;
        expect_evt(1'b1, UP);
        tick(5);
        check("fail_to_up", 32'(link_up), 32'h3);
        check("fail_all_up", 32'(all_up), 1);
        check("tmo_sticky", 32'(timeout_err), 32'h2);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        check("tmo_cleared", 32'(timeout_err), 0);
        check("clr_keeps_up", 32'(link_up), 32'h3);
        tick(5);

        // glitch table on port0 link_init, drop counter saturates at 3
        for (int i = 0; i < 8; i++) begin
            if (gt[i].drop) begin
                expect_evt(1'b0, DN);
                expect_evt(1'b0, UP);
            end
            link_init[0] = 1'b0;
            tick(gt[i].len);
            link_init[0] = 1'b1;
            tick(16);
            check($sformatf("glitch%0d_drop", i), 32'(drop_cnt[0 +: CW]), 32'(gt[i].exp_drop));
            check($sformatf("glitch%0d_up", i), 32'(link_up[0]), 1);
        end

        // clr_stats in the same cycle as a drop increment
        expect_evt(1'b0, DN);
        expect_evt(1'b0, UP);
        link_init[0] = 1'b0;
        tick(4);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        link_init[0] = 1'b1;
        check("clr_vs_drop_cnt", 32'(drop_cnt[0 +: CW]), 0);
        check("clr_vs_drop_down", 32'(link_up[0]), 0);
        tick(16);
        check("clr_vs_drop_reup", 32'(link_up[0]), 1);
        check("ovf_clean", 32'(evt_overflow), 0);

        // arbitration and overflow with the consumer stalled
        evt_ready = 1'b0;
        clk_lock = '0;
        tick(10);
        clk_lock = '1;
        tick(16);
        check("arb_both_up", 32'(link_up), 32'h3);
        check("arb_overflow", 32'(evt_overflow), 1);
        check("arb_hold_valid", 32'(evt_valid), 1);
        check("arb_hold_event", {30'(evt_port), evt_code}, {30'd1, DN});
        link_init[0] = 1'b0;
        tick(6);
        check("arb_p0_down", 32'(link_up[0]), 0);
        expect_evt(1'b1, DN);
        expect_evt(1'b0, DN);
        expect_evt(1'b1, UP);
        evt_ready = 1'b1;
        tick(10);
        check("arb_drop0", 32'(drop_cnt[0 +: CW]), 2);
        check("arb_drop1", 32'(drop_cnt[CW +: CW]), 1);
        check("arb_drained", 32'(exp_q.size()), 0);
        clr_stats = 1'b1;
        tick(1);
        clr_stats = 1'b0;
        check("ovf_cleared", 32'(evt_overflow), 0);

        // reset mid-operation with both ports UP and an event pending
        evt_ready = 1'b0;
        link_init[0] = 1'b1;
        tick(16);
        check("pre_rst_all_up", 32'(all_up), 1);
        check("pre_rst_pending", 32'(evt_valid), 1);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        check("midrst_link_up", 32'(link_up), 0);
        check("midrst_evt_valid", 32'(evt_valid), 0);
        check("midrst_drop_cnt", 32'(drop_cnt), 0);
        check("midrst_mode_1x_f", 32'(mode_1x_f), 0);
        evt_ready = 1'b1;
        expect_evt(1'b0, UP);
        expect_evt(1'b1, UP);
        tick(4);
        check("rebring_mode_1x_f", 32'(mode_1x_f), 32'h1);
        tick(2);
        check("rebring_early", 32'(link_up), 0);
        tick(1);
        check("rebring_up", 32'(link_up), 32'h3);
        tick(10);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
